out_uart_tx: RTL and testbench

- Downstream debug stage for the CPU: watches the 4-bit `out_pins_o` bus of the CPU.
- Each time the value changes, the new nibble is queued in a small FIFO.
- Each queued nibble is sent as one ASCII hex character ('0'-'9', 'A'-'F') on a UART line.
- UART format is 8N1 with the same bit timing the programmer's receiver expects, so a host can watch program output on the same serial link used for programming.

---
 rtl/out_uart_tx.sv | 171 +++++++++++++++++
 tb/tb_out_uart_tx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/out_uart_tx.sv
// Debug tap on the CPU output bus. Every change of the bus value is queued and
// sent on the UART line as one ASCII hex character, 8N1.
module out_uart_tx #(
    parameter int unsigned DATA_WIDTH      = 4,
    parameter int unsigned CLKS_PER_BIT    = 521,
    parameter int unsigned FIFO_DEPTH      = 4,
    parameter int unsigned FIFO_ADDR_WIDTH = 2
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [DATA_WIDTH-1:0] out_pins_i,
    input  logic                  enable_i,
    output logic                  tx_o,
    output logic                  busy_o,
    output logic                  overflow_o
);

    localparam int unsigned CNT_W  = FIFO_ADDR_WIDTH + 1;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    logic [DATA_WIDTH-1:0]      last_val;
    logic [DATA_WIDTH-1:0]      fifo_mem [FIFO_DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0] wr_ptr;
    logic [FIFO_ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]           count;

    logic [1:0]        state,    state_n;
    logic [BAUD_W-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]        bit_idx,  bit_idx_n;
    logic [7:0]        shift_reg, shift_reg_n;
    logic              tx_n;

    logic push_req_c;
    logic fifo_full_c;
    logic pop_c;
    logic push_c;

    // Nibble to ASCII hex digit, upper-case letters
    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    assign push_req_c  = enable_i && (out_pins_i != last_val);
    assign fifo_full_c = (count == CNT_FULL);
    assign pop_c       = (state == ST_IDLE) && (count != '0);
    // A pop in the same cycle frees a slot, so a push at full is still accepted
    assign push_c      = push_req_c && (!fifo_full_c || pop_c);

    assign busy_o = (state != ST_IDLE) || (count != '0);

    // Change detector history, tracked even while capture is disabled
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            last_val <= '0;
        end else begin
            last_val <= out_pins_i;
        end
    end

    // Nibble FIFO and sticky overflow flag
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push_c) begin
                fifo_mem[wr_ptr] <= out_pins_i;
                wr_ptr           <= wr_ptr + FIFO_ADDR_WIDTH'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + FIFO_ADDR_WIDTH'(1);
            end
            if (push_c && !pop_c) begin
                count <= count + CNT_W'(1);
            end else if (pop_c && !push_c) begin
                count <= count - CNT_W'(1);
            end
            if (push_req_c && !push_c) begin
                overflow_o <= 1'b1;
            end
        end
    end

    // TX state register; tx_o is registered from the current state, so each
    // line level appears one cycle after the state that produces it
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state     <= ST_IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_o      <= 1'b1;
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_cnt_n;
            bit_idx   <= bit_idx_n;
            shift_reg <= shift_reg_n;
            tx_o      <= tx_n;
        end
    end

    // TX next-state and line level
    always_comb begin
        state_n     = state;
        baud_cnt_n  = baud_cnt;
        bit_idx_n   = bit_idx;
        shift_reg_n = shift_reg;
        tx_n        = 1'b1;
        case (state)
            ST_IDLE: begin
                tx_n = 1'b1;
                if (pop_c) begin
                    shift_reg_n = hex_ascii(4'(fifo_mem[rd_ptr]));
                    baud_cnt_n  = '0;
                    state_n     = ST_START;
                end
            end
            ST_START: begin
                tx_n = 1'b0;
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = '0;
                    state_n    = ST_DATA;
                end else begin
                    baud_cnt_n = baud_cnt + BAUD_W'(1);
                end
            end
            ST_DATA: begin
                tx_n = shift_reg[0];
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_n  = '0;
                    shift_reg_n = {1'b0, shift_reg[7:1]};
                    bit_idx_n   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_n = ST_STOP;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + BAUD_W'(1);
                end
            end
            ST_STOP: begin
                tx_n = 1'b1;
                if (baud_cnt == BAUD_LAST) begin
                    baud_cnt_n = '0;
                    state_n    = ST_IDLE;
                end else begin
                    baud_cnt_n = baud_cnt + BAUD_W'(1);
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_out_uart_tx.sv
// Bench for out_uart_tx: a fast instance (4 clocks/bit) driven by directed steps
// with a UART-decoding scoreboard, plus one frame on a 521 clocks/bit instance.
module tb_out_uart_tx;

    localparam int unsigned CPB      = 4;
    localparam int unsigned SLOW_CPB = 521;

    logic       clk = 1'b0;
    logic       reset_i, enable_i, tx_o, busy_o, overflow_o;
    logic [3:0] out_pins_i;
    logic       reset_s, enable_s, tx_s, busy_s, overflow_s;
    logic [3:0] out_pins_s;

    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [8:0] exp_q [$];
    logic       mon_en   = 1'b0;
    logic       mon_busy = 1'b0;

    always #5 clk = ~clk;

    out_uart_tx #(.DATA_WIDTH(4), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(4), .FIFO_ADDR_WIDTH(2)) u_dut (
        .clk_i(clk), .reset_i(reset_i), .out_pins_i(out_pins_i), .enable_i(enable_i),
        .tx_o(tx_o), .busy_o(busy_o), .overflow_o(overflow_o)
    );

    out_uart_tx #(.DATA_WIDTH(4), .CLKS_PER_BIT(SLOW_CPB), .FIFO_DEPTH(4), .FIFO_ADDR_WIDTH(2)) u_slow (
        .clk_i(clk), .reset_i(reset_s), .out_pins_i(out_pins_s), .enable_i(enable_s),
        .tx_o(tx_s), .busy_o(busy_s), .overflow_o(overflow_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy_o !== 1'b0 || mon_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < budget), 32'd1);
    endtask

    // UART decoder: samples mid-bit and pops the scoreboard at each stop bit
    initial begin
        logic [7:0] b;
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (mon_en && !mon_busy && tx_o === 1'b0) begin
                mon_busy = 1'b1;
                repeat (CPB / 2) @(negedge clk);
                chk("start_bit", 32'(tx_o), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx_o;
                end
                repeat (CPB) @(negedge clk);
                chk("stop_bit", 32'(tx_o), 32'd1);
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF;
                chk("frame", 32'({1'b0, b}), 32'(e));
                mon_busy = 1'b0;
            end
        end
    end

    initial begin
        int         lows;
        logic [7:0] sb;
        int         n;

        reset_i = 1'b1; reset_s = 1'b1;
        out_pins_i = 4'h0; out_pins_s = 4'h0;
        enable_i = 1'b1; enable_s = 1'b1;
        mon_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_tx", 32'(tx_o), 32'd1);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);
        reset_i = 1'b0; reset_s = 1'b0;
        @(negedge clk);

        // single change 0 -> 5: start bit on the third edge after the change
        out_pins_i = 4'h5; exp_q.push_back(9'h035);
        @(negedge clk);
        chk("busy_after_push", 32'(busy_o), 32'd1);
        chk("tx_edge1", 32'(tx_o), 32'd1);
        @(negedge clk);
        chk("tx_edge2", 32'(tx_o), 32'd1);
        @(negedge clk);
        chk("start_latency", 32'(tx_o), 32'd0);
        lows = 1;
        @(negedge clk);
        while (tx_o === 1'b0 && lows < 20) begin
            lows++;
            @(negedge clk);
        end
        chk("start_width", 32'(lows), 32'(CPB));
        wait_idle(200);
        chk("idle_tx", 32'(tx_o), 32'd1);

        // hex letters, repeated value produces nothing
        out_pins_i = 4'hA; exp_q.push_back(9'h041);
        repeat (2) @(negedge clk);
        wait_idle(200);
        out_pins_i = 4'hA;
        repeat (5) @(negedge clk);
        chk("no_repeat_frame", 32'(busy_o), 32'd0);
        out_pins_i = 4'hF; exp_q.push_back(9'h046);
        repeat (2) @(negedge clk);
        wait_idle(200);

        // enable gating: history still tracks, so re-enabling sends nothing
        enable_i = 1'b0;
        out_pins_i = 4'h0; @(negedge clk);
        out_pins_i = 4'h7; @(negedge clk);
        out_pins_i = 4'h3; @(negedge clk);
        enable_i = 1'b1;
        repeat (10) @(negedge clk);
        chk("gated_no_frame", 32'(busy_o), 32'd0);
        out_pins_i = 4'h9; exp_q.push_back(9'h039);
        repeat (2) @(negedge clk);
        wait_idle(200);

        // burst 1..6: '1' goes to the shifter, 2..5 fill the FIFO, 6 dropped
        for (int v = 1; v <= 6; v++) begin
            out_pins_i = 4'(v);
            if (v < 6) exp_q.push_back(9'(48 + v));
            @(negedge clk);
        end
        chk("overflow_set", 32'(overflow_o), 32'd1);
        wait_idle(400);
        chk("overflow_sticky", 32'(overflow_o), 32'd1);

        reset_i = 1'b1; out_pins_i = 4'h0;
        @(negedge clk);
        chk("overflow_cleared", 32'(overflow_o), 32'd0);
        reset_i = 1'b0;
        @(negedge clk);

        // fill to full, then land a push on the IDLE pop edge
        for (int v = 1; v <= 5; v++) begin
            out_pins_i = 4'(v); exp_q.push_back(9'(48 + v));
            @(negedge clk);
        end
        repeat (10 * CPB + 3 - 6) @(negedge clk);
        out_pins_i = 4'h6; exp_q.push_back(9'h036);
        @(negedge clk);
        chk("push_pop_full_no_ovf", 32'(overflow_o), 32'd0);
        wait_idle(600);
        chk("ovf_still_clear", 32'(overflow_o), 32'd0);

        // reset mid-frame
        mon_en = 1'b0;
        out_pins_i = 4'h8;
        repeat (10) @(negedge clk);
        chk("midframe_tx_low", 32'(tx_o), 32'd0);
        reset_i = 1'b1; out_pins_i = 4'h0;
        #1;
        chk("reset_tx_async", 32'(tx_o), 32'd1);
        chk("reset_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        reset_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_reset_idle", 32'(busy_o), 32'd0);
        mon_en = 1'b1;

        // one frame at full bit timing: 'C' = 8'h43
        out_pins_s = 4'hC;
        repeat (3) @(negedge clk);
        chk("slow_start", 32'(tx_s), 32'd0);
        repeat (SLOW_CPB - 1) @(negedge clk);
        chk("slow_start_end", 32'(tx_s), 32'd0);
        @(negedge clk);
        chk("slow_bit0_edge", 32'(tx_s), 32'd1);
        repeat (SLOW_CPB / 2) @(negedge clk);
        sb[0] = tx_s;
        for (int i = 1; i < 8; i++) begin
            repeat (SLOW_CPB) @(negedge clk);
            sb[i] = tx_s;
        end
        repeat (SLOW_CPB) @(negedge clk);
        chk("slow_stop", 32'(tx_s), 32'd1);
        chk("slow_frame", 32'(sb), 32'h43);
        n = 0;
        while (busy_s !== 1'b0 && n < 2 * SLOW_CPB) begin
            @(negedge clk);
            n++;
        end
        chk("slow_idle_timeout", 32'(n < 2 * SLOW_CPB), 32'd1);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
